alu_nibble_seq: RTL and testbench
=================================

Name: alu_nibble_seq

Overview:
Multi-cycle sequencer that runs wide (4×NIBBLES-bit) arithmetic and logic operations through the single 4-bit ALU, one nibble per clock, LSB nibble first. It owns the ALU's a/b/s/m/crin inputs, chains carry between nibbles and assembles the wide result. It sits between the CPU control unit and the ALU: start/busy/done handshake upstream, direct combinational ALU connection downstream.

Parameters:
NIBBLES, 4, operand width in nibbles (legal 1..8); data width W = 4*NIBBLES

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
op  input  3  operation code, latched on accepted start
opa  input  W  operand A, latched on accepted start
opb  input  W  operand B, latched on accepted start
cin  input  1  carry-in for ADC, latched on accepted start
alu_a  output  4  current nibble of latched A to ALU
alu_b  output  4  current nibble of latched B to ALU
alu_s  output  4  ALU function select
alu_m  output  1  ALU mode (1 = logic)
alu_crin  output  1  ALU carry-in for current nibble
alu_f  input  4  ALU result nibble
alu_crout  input  1  ALU carry-out
result  output  W  assembled result, held until next accepted start
cout  output  1  final carry (ADD/ADC/INC: carry; SUB: 1 = no borrow); 0 for logic ops
zero  output  1  1 when result == 0, updated with done
busy  output  1  operation in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse: start with illegal op

Behaviour:
- Op map (alu_m, alu_s, first-nibble crin): 0 ADD (0,9,0); 1 SUB A-B (0,6,1); 2 ADC (0,9,cin); 3 INC A+1 (0,0,1); 4 NOR (1,1,0); 5 MOVB (1,A,0); 6,7 illegal.
- States: IDLE, RUN, DONE.
- IDLE: alu_a=alu_b=0, alu_s=0, alu_m=0, alu_crin=0 (ALU never sees undefined select). start=1 with legal op: latch op/opa/opb/cin, idx<=0, carry<=first-nibble crin, result<=0, go RUN. start=1 with illegal op: err=1 next cycle, stay IDLE, result/cout/zero unchanged. start=0: stay.
- RUN: drive alu_a=opa[4*idx+:4], alu_b=opb[4*idx+:4], alu_s/alu_m per op, alu_crin=carry (arith) or 0 (logic). Each cycle: result[4*idx+:4]<=alu_f; carry<=alu_crout for arith ops, 0 for logic; idx<=idx+1. At idx==NIBBLES-1: cout<=final carry (0 for logic), zero<=(assembled result==0), go DONE.
- DONE: done=1, busy=1 for exactly one cycle; ALU inputs driven as IDLE; next state IDLE.
- busy=1 in RUN and DONE, 0 in IDLE. start while busy is ignored (not queued, no err).
- Latency: start accepted at edge T -> done high during cycle T+NIBBLES+1 (i.e., NIBBLES RUN cycles + 1 DONE cycle); next start accepted in the cycle after done.
- result bits for nibbles not yet processed read 0 during RUN; result is only architecturally valid while/after done.
- Reset (rst_n=0 at edge): state IDLE, idx=0, carry=0, result=0, cout=0, zero=0, busy=0, done=0, err=0. Reset mid-RUN aborts silently: no done pulse, partial result cleared.
- NIBBLES=1: single RUN cycle, done at T+2.
- idx width = clog2(NIBBLES) or 1 minimum; idx never exceeds NIBBLES-1.

Test Plan:
1. NIBBLES=4, ADD opa=0x1234 opb=0x0FFF -> busy 4+1 cycles, done at T+5, result=0x2233, cout=0, zero=0; alu_s=9 every RUN cycle, alu_crin chain 0,1,1,1.
2. ADD 0xFFFF+0x0001 -> result=0x0000, cout=1, zero=1; ADC 0x00FF+0x0000 cin=1 -> result=0x0100, cout=0.
3. SUB 0x1000-0x0001 -> result=0x0FFF, cout=1; SUB 0x0001-0x0002 -> result=0xFFFF, cout=0; INC 0xFFFF -> 0x0000, cout=1, zero=1.
4. NOR opa=0xF0F0 opb=0x0F00 -> result=0x000F, cout=0, alu_m=1 alu_s=1 alu_crin=0; MOVB opb=0xBEEF -> 0xBEEF, alu_s=0xA.
5. start with op=6 -> err=1 one cycle, busy stays 0, result unchanged; start pulsed during RUN of an ADD -> ignored, ADD result correct, single done.
6. rst_n=0 on second RUN cycle of ADD -> next cycle busy=0, result=0, cout=0, no done; subsequent ADD 0x0001+0x0001 -> 0x0002 with normal latency.

Source files
------------

// File: rtl/alu_nibble_seq.sv
// Nibble-serial sequencer: pushes a 4*NIBBLES-bit operation through an external
// 4-bit ALU one nibble per clock, LSB first, chaining carry and assembling the result.

package alu_nibble_seq_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_ADC  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_MOVB = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // Everything the sequencer needs to know about an op code, in one place.
  typedef struct packed {
    logic       legal;
    logic       arith;     // carry chains between nibbles
    logic       m;
    logic [3:0] s;
    logic       crin_one;  // first-nibble carry-in forced to 1
    logic       crin_cin;  // first-nibble carry-in taken from cin
  } op_dec_t;

  function automatic op_dec_t decode_op(input logic [2:0] op);
    op_dec_t d;
    d       = '0;
    d.legal = 1'b1;
    case (op)
      OP_ADD:  begin d.arith = 1'b1; d.s = 4'h9;                   end
      OP_SUB:  begin d.arith = 1'b1; d.s = 4'h6; d.crin_one = 1'b1; end
      OP_ADC:  begin d.arith = 1'b1; d.s = 4'h9; d.crin_cin = 1'b1; end
      OP_INC:  begin d.arith = 1'b1; d.s = 4'h0; d.crin_one = 1'b1; end
      OP_NOR:  begin d.m     = 1'b1; d.s = 4'h1;                   end
      OP_MOVB: begin d.m     = 1'b1; d.s = 4'hA;                   end
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [4*NIBBLES-1:0]   opa,
  input  logic [4*NIBBLES-1:0]   opb,
  input  logic                   cin,
  output logic [3:0]             alu_a,
  output logic [3:0]             alu_b,
  output logic [3:0]             alu_s,
  output logic                   alu_m,
  output logic                   alu_crin,
  input  logic [3:0]             alu_f,
  input  logic                   alu_crout,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   zero,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  logic [IDXW+1:0]   bit_base;
  logic              carry_q;
  logic [2:0]        op_q;
  logic [W-1:0]      opa_q, opb_q;
  logic [W-1:0]      result_nxt;
  op_dec_t           start_dec, run_dec;
  logic              accept;
  logic              last_nibble;

  assign start_dec   = decode_op(op);
  assign run_dec     = decode_op(op_q);
  assign accept      = (state_q == S_IDLE) && start && start_dec.legal;
  assign last_nibble = (idx_q == LAST_IDX);
  assign bit_base    = {idx_q, 2'b00};

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case/if leaves it unassigned and a latch is never inferred.
  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept)      state_d = S_RUN;
      S_RUN:   if (last_nibble) state_d = S_DONE;
      S_DONE:                   state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Outside RUN the ALU sees an all-zero, fully defined control word.
  always_comb begin : alu_drive
    alu_a    = '0;
    alu_b    = '0;
    alu_s    = '0;
    alu_m    = 1'b0;
    alu_crin = 1'b0;
    if (state_q == S_RUN) begin
      alu_a    = opa_q[bit_base +: 4];
      alu_b    = opb_q[bit_base +: 4];
      alu_s    = run_dec.s;
      alu_m    = run_dec.m;
      alu_crin = run_dec.arith & carry_q;
    end
  end

  always_comb begin : result_merge
    result_nxt                = result;
    result_nxt[bit_base +: 4] = alu_f;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      zero    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      err     <= (state_q == S_IDLE) && start && !start_dec.legal;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            idx_q   <= '0;
            carry_q <= start_dec.crin_one | (start_dec.crin_cin & cin);
            result  <= '0;
          end
        end
        S_RUN: begin
          result  <= result_nxt;
          carry_q <= run_dec.arith & alu_crout;
          if (last_nibble) begin
            cout  <= run_dec.arith & alu_crout;
            zero  <= (result_nxt == '0);
            idx_q <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: operand latches carry no reset; they are only read in RUN, which is
  // reachable solely through an accepted start that loads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q  <= op;
      opa_q <= opa;
      opb_q <= opb;
    end
  end

  idx_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    idx_q <= LAST_IDX);

  done_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Randomised scoreboard bench for alu_nibble_seq with a behavioural 4-bit ALU
// attached and a wide-arithmetic reference model.

module tb_alu_nibble_seq;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa, opb;
  logic         cin;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_crin, alu_crout;
  logic [W-1:0] result;
  logic         cout, zero, busy, done, err;

  always #5 clk = ~clk;

  alu_nibble_seq #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
    .cin      (cin),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_s    (alu_s),
    .alu_m    (alu_m),
    .alu_crin (alu_crin),
    .alu_f    (alu_f),
    .alu_crout(alu_crout),
    .result   (result),
    .cout     (cout),
    .zero     (zero),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Behavioural 4-bit ALU (only the select codes the sequencer uses).
  logic [4:0] alu_sum;
  always_comb begin
    alu_sum   = '0;
    alu_f     = '0;
    alu_crout = 1'b0;
    if (alu_m) begin
      case (alu_s)
        4'h1:    alu_f = ~(alu_a | alu_b);
        4'hA:    alu_f = alu_b;
        default: alu_f = 4'h0;
      endcase
    end else begin
      case (alu_s)
        4'h9:    alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_crin);
        4'h6:    alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_crin);
        4'h0:    alu_sum = {1'b0, alu_a} + 5'(alu_crin);
        default: alu_sum = '0;
      endcase
      alu_f     = alu_sum[3:0];
      alu_crout = alu_sum[4];
    end
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         c;
    int           t0;
    logic [W-1:0] r;
    logic         co;
  } exp_t;

  localparam logic [3:0] EXP_S [8] = '{4'h9, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h0, 4'h0};
  localparam logic       EXP_M [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [W-1:0] last_result;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wide-word reference: the whole operation in one step of plain arithmetic.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, output logic [W-1:0] r, output logic co);
    r  = '0;
    co = 1'b0;
    case (o)
      3'd0: {co, r} = {1'b0, a} + {1'b0, b};
      3'd1: begin r = a - b; co = (a >= b); end
      3'd2: {co, r} = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      3'd3: {co, r} = {1'b0, a} + (W+1)'(1);
      3'd4: r = ~(a | b);
      3'd5: r = b;
      default: ;
    endcase
  endfunction

  // Carry entering nibble k = carry out of the sum of the k low nibbles.
  function automatic logic crin_at(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input int k);
    logic [63:0] mask, la, lb, sum;
    mask = (64'd1 << (4 * k)) - 64'd1;
    la   = 64'(a) & mask;
    lb   = 64'(b) & mask;
    case (o)
      3'd0:    sum = la + lb;
      3'd1:    sum = la + (~64'(b) & mask) + 64'd1;
      3'd2:    sum = la + lb + 64'(c);
      3'd3:    sum = la + 64'd1;
      default: sum = 64'd0;
    endcase
    return sum[4 * k];
  endfunction

  // Monitor: checks ALU drive per RUN cycle and the result on done.
  int   k = 0;
  exp_t m_e;
  always @(negedge clk) begin
    if (!busy) begin
      k = 0;
      check("idle_alu_inputs", {alu_a, alu_b, alu_s, alu_m, alu_crin}, '0);
      check("idle_no_done", done, 0);
    end else if (done) begin
      check("done_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        m_e = sb.pop_front();
        check("run_cycles", k, N);
        check("latency", cyc - m_e.t0, N);
        check("result", result, m_e.r);
        check("cout", cout, m_e.co);
        check("zero", zero, m_e.r == '0);
        check("done_alu_inputs", {alu_a, alu_b, alu_s, alu_m, alu_crin}, '0);
      end
      k = 0;
    end else begin
      check("run_has_entry", sb.size() != 0, 1);
      check("run_not_overlong", k < N, 1);
      if (sb.size() != 0 && k < N) begin
        m_e = sb[0];
        check("alu_a", alu_a, m_e.a[4*k +: 4]);
        check("alu_b", alu_b, m_e.b[4*k +: 4]);
        check("alu_s", alu_s, EXP_S[m_e.op]);
        check("alu_m", alu_m, EXP_M[m_e.op]);
        check("alu_crin", alu_crin, crin_at(m_e.op, m_e.a, m_e.b, m_e.c, k));
        check("unprocessed_zero", result >> (4 * k), 0);
      end
      k++;
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", busy, 0);
  endtask

  // Called on a negedge with the DUT idle. mode: 0 normal, 1 start poked mid-RUN, 2 reset mid-RUN.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input int mode);
    exp_t e;
    start = 1'b1; op = o; opa = a; opb = b; cin = c;
    e.op = o; e.a = a; e.b = b; e.c = c; e.t0 = cyc + 1;
    model(o, a, b, c, e.r, e.co);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; op = 3'($urandom); opa = W'($urandom); opb = W'($urandom); cin = 1'($urandom);
    if (mode == 1) begin
      start = 1'b1;
      op    = 3'($urandom_range(0, 7));
      @(negedge clk);
      start = 1'b0;
      check("busy_start_no_err", err, 0);
    end
    if (mode == 2) begin
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 0);
      check("abort_cout", cout, 0);
      check("abort_zero", zero, 0);
      void'(sb.pop_back());
      last_result = '0;
    end else begin
      wait_idle(4 * N + 8);
      last_result = e.r;
    end
  endtask

  task automatic issue_illegal(input logic [2:0] o);
    start = 1'b1; op = o; opa = W'($urandom); opb = W'($urandom); cin = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    check("err_result_kept", result, last_result);
    @(negedge clk);
    check("err_one_cycle", err, 0);
    check("err_still_idle", busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; opa = '0; opb = '0; cin = 1'b0;
    last_result = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_result", result, 0);
    check("reset_cout", cout, 0);
    check("reset_zero", zero, 0);

    run_op(3'd0, 16'h1234, 16'h0FFF, 1'b0, 0);
    run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(3'd2, 16'h00FF, 16'h0000, 1'b1, 0);
    run_op(3'd1, 16'h1000, 16'h0001, 1'b0, 0);
    run_op(3'd1, 16'h0001, 16'h0002, 1'b0, 0);
    run_op(3'd3, 16'hFFFF, 16'h1234, 1'b0, 0);
    run_op(3'd4, 16'hF0F0, 16'h0F00, 1'b0, 0);
    run_op(3'd5, 16'h1357, 16'hBEEF, 1'b0, 0);
    issue_illegal(3'd6);
    issue_illegal(3'd7);
    run_op(3'd0, 16'h4321, 16'h1111, 1'b0, 1);
    run_op(3'd0, 16'h5555, 16'h7777, 1'b0, 2);
    run_op(3'd0, 16'h0001, 16'h0001, 1'b0, 0);

    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) issue_illegal(3'($urandom_range(6, 7)));
      else run_op(3'($urandom_range(0, 5)), W'($urandom), W'($urandom), 1'($urandom),
                  (sel == 1) ? 1 : ((sel == 2) ? 2 : 0));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d comparisons made", n_vec);
    $fatal(1, "timeout");
  end

endmodule
